// File: rtl/huc6270_pkg.sv
// Shared definitions for the HuC6270 register-port arbiter: register indices,
// sequencer states and strobe helpers.
package huc6270_pkg;

    localparam logic [4:0] REG_MAWR = 5'h00;
    localparam logic [4:0] REG_MARR = 5'h01;
    localparam logic [4:0] REG_VWR  = 5'h02;
    localparam logic [4:0] REG_VRR  = 5'h02;
    localparam logic [4:0] REG_CR   = 5'h05;
    localparam logic [4:0] REG_RCR  = 5'h06;
    localparam logic [4:0] REG_BXR  = 5'h07;
    localparam logic [4:0] REG_BYR  = 5'h08;
    localparam logic [4:0] REG_MWR  = 5'h09;
    localparam logic [4:0] REG_LAST = 5'h13;

    localparam int STB_CW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        ACC  = 2'd2,
        REL  = 2'd3
    } vdc_state_e;

    // {WRn, RDn, A2} of the data phase; status reads go to A2=0.
    function automatic logic [2:0] acc_strobes(input logic sr, input logic we);
        logic [2:0] s;
        if (sr) begin
            s = 3'b100;
        end else if (we) begin
            s = 3'b011;
        end else begin
            s = 3'b101;
        end
        return s;
    endfunction

    function automatic logic [15:0] sel_word(input logic [4:0] r);
        return {11'b0, r};
    endfunction

endpackage

// File: rtl/huc6270_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner when the
// grant is accepted.
module huc6270_rr_arb (
    input  logic       CLK,
    input  logic       RES,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic ptr_r;

    // Winner selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ptr_r;
            default: gnt_id = 1'b0;
        endcase
    end

    // Pointer update on an accepted grant.
    always_ff @(posedge CLK) begin
        if (RES) begin
            ptr_r <= 1'b0;
        end else if (accept && gnt_valid) begin
            ptr_r <= ~gnt_id;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/huc6270_port_arb.sv
// Shares the HuC6270 register port between two requesters, issuing each access
// as an atomic select-write plus data access, with a shadow of the chip's select.
module huc6270_port_arb
    import huc6270_pkg::*;
#(
    parameter int SKIP_SEL = 1,
    parameter int STB_CYC  = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [1:0]  REQ,
    input  logic [1:0]  REQ_SR,
    input  logic [1:0]  WE,
    input  logic [4:0]  REG0,
    input  logic [4:0]  REG1,
    input  logic [15:0] WD0,
    input  logic [15:0] WD1,
    output logic [1:0]  ACK,
    output logic [15:0] RD0,
    output logic [15:0] RD1,
    output logic        VDC_CSn,
    output logic        VDC_WRn,
    output logic        VDC_RDn,
    output logic        VDC_A2,
    output logic [15:0] VDC_DO,
    input  logic [15:0] VDC_DI
);

    localparam logic [STB_CW-1:0] STB_LAST = STB_CW'(STB_CYC - 1);

    vdc_state_e        state_r;
    logic [STB_CW-1:0] cnt_r;
    logic              gnt_id_r;
    logic              sr_r;
    logic              we_r;
    logic [4:0]        reg_r;
    logic [15:0]       wd_r;
    logic [15:0]       cap_r;
    logic [4:0]        shadow_r;
    logic              shadow_vld_r;

    logic [1:0]        req_s;
    logic              accept_s;
    logic              gnt_valid_s;
    logic              gnt_id_s;
    logic              win_sr_s;
    logic              win_we_s;
    logic [4:0]        win_reg_s;
    logic [15:0]       win_wd_s;
    logic              need_sel_s;
    logic              last_s;

    // A requester is ignored while its own ACK is high.
    assign req_s    = REQ & ~ACK;
    assign accept_s = CE && (state_r == IDLE);
    assign last_s   = (cnt_r == STB_LAST);

    huc6270_rr_arb u_arb (
        .CLK       (CLK),
        .RES       (RES),
        .req       (req_s),
        .accept    (accept_s),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // Winner's request fields and whether its select write can be skipped.
    always_comb begin
        if (gnt_id_s) begin
            win_sr_s  = REQ_SR[1];
            win_we_s  = WE[1];
            win_reg_s = REG1;
            win_wd_s  = WD1;
        end else begin
            win_sr_s  = REQ_SR[0];
            win_we_s  = WE[0];
            win_reg_s = REG0;
            win_wd_s  = WD0;
        end
        if (win_sr_s) begin
            need_sel_s = 1'b0;
        end else if ((SKIP_SEL != 0) && shadow_vld_r && (shadow_r == win_reg_s)) begin
            need_sel_s = 1'b0;
        end else begin
            need_sel_s = 1'b1;
        end
    end

    // Access sequencer with registered port strobes, shadow select and read data.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_r      <= IDLE;
            cnt_r        <= {STB_CW{1'b0}};
            gnt_id_r     <= 1'b0;
            sr_r         <= 1'b0;
            we_r         <= 1'b0;
            reg_r        <= 5'h00;
            wd_r         <= 16'h0000;
            cap_r        <= 16'h0000;
            shadow_r     <= 5'h00;
            shadow_vld_r <= 1'b0;
            ACK          <= 2'b00;
            RD0          <= 16'h0000;
            RD1          <= 16'h0000;
            VDC_CSn      <= 1'b1;
            VDC_WRn      <= 1'b1;
            VDC_RDn      <= 1'b1;
            VDC_A2       <= 1'b0;
            VDC_DO       <= 16'h0000;
        end else begin
            ACK <= 2'b00;
            if (CE) begin
                case (state_r)
                    IDLE: begin
                        if (gnt_valid_s) begin
                            gnt_id_r <= gnt_id_s;
                            sr_r     <= win_sr_s;
                            we_r     <= win_we_s;
                            reg_r    <= win_reg_s;
                            wd_r     <= win_wd_s;
                            cnt_r    <= {STB_CW{1'b0}};
                            VDC_CSn  <= 1'b0;
                            if (need_sel_s) begin
                                state_r      <= SEL;
                                VDC_WRn      <= 1'b0;
                                VDC_RDn      <= 1'b1;
                                VDC_A2       <= 1'b0;
                                VDC_DO       <= sel_word(win_reg_s);
                                shadow_r     <= win_reg_s;
                                shadow_vld_r <= 1'b1;
                            end else begin
                                state_r <= ACC;
                                {VDC_WRn, VDC_RDn, VDC_A2} <= acc_strobes(win_sr_s, win_we_s);
                                if (win_we_s && !win_sr_s) begin
                                    VDC_DO <= win_wd_s;
                                end
                            end
                        end
                    end
                    SEL: begin
                        if (last_s) begin
                            state_r <= ACC;
                            cnt_r   <= {STB_CW{1'b0}};
                            {VDC_WRn, VDC_RDn, VDC_A2} <= acc_strobes(sr_r, we_r);
                            if (we_r && !sr_r) begin
                                VDC_DO <= wd_r;
                            end
                        end else begin
                            cnt_r <= cnt_r + STB_CW'(1);
                        end
                    end
                    ACC: begin
                        if (last_s) begin
                            state_r <= REL;
                            cnt_r   <= {STB_CW{1'b0}};
                            VDC_CSn <= 1'b1;
                            VDC_WRn <= 1'b1;
                            VDC_RDn <= 1'b1;
                            cap_r   <= VDC_DI;
                        end else begin
                            cnt_r <= cnt_r + STB_CW'(1);
                        end
                    end
                    REL: begin
                        state_r <= IDLE;
                        ACK     <= gnt_id_r ? 2'b10 : 2'b01;
                        // Read data only moves on reads; a write ACK leaves RDg as it was.
                        if (sr_r || !we_r) begin
                            if (gnt_id_r) begin
                                RD1 <= cap_r;
                            end else begin
                                RD0 <= cap_r;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_huc6270_port_arb.sv
// Bench for huc6270_port_arb: three instances (default, SKIP_SEL=0, STB_CYC=2
// with slow CE) against a chip model and an access-level reference model.
module tb_huc6270_port_arb;

    typedef struct packed {
        logic        wr;
        logic        a2;
        logic [15:0] data;
        logic [7:0]  len;
    } seg_t;

    logic        clk = 1'b0;
    logic        res [3];
    logic        ce [3];
    logic [1:0]  req [3];
    logic [1:0]  req_sr [3];
    logic [1:0]  we [3];
    logic [4:0]  reg0 [3];
    logic [4:0]  reg1 [3];
    logic [15:0] wd0 [3];
    logic [15:0] wd1 [3];
    logic [1:0]  ack [3];
    logic [15:0] rd0 [3];
    logic [15:0] rd1 [3];
    logic        csn [3];
    logic        wrn [3];
    logic        rdn [3];
    logic        a2 [3];
    logic [15:0] vdo [3];
    logic [15:0] vdi [3];

    // chip model
    logic [15:0] cmem [3][32];
    logic [4:0]  rsel [3];
    logic        vd [3];

    // reference model
    logic [15:0] emem [3][32];
    logic        shv [3];
    logic [4:0]  shr [3];
    int          rrp [3];
    logic [15:0] erd [3][2];
    logic        vd_exp [3];
    int          cepd [3];
    int          skip_p [3] = '{1, 0, 1};
    int          stb_p [3]  = '{1, 1, 2};

    seg_t        log_q [3][$];
    seg_t        exp_q [3][$];
    seg_t        cur [3];
    logic        act [3];
    logic [18:0] key_r [3];
    int          cyc;
    bit          ce_en;
    int          checks;
    int          failures;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        huc6270_port_arb #(
            .SKIP_SEL (gi == 1 ? 0 : 1),
            .STB_CYC  (gi == 2 ? 2 : 1)
        ) u_dut (
            .CLK     (clk),
            .RES     (res[gi]),
            .CE      (ce[gi]),
            .REQ     (req[gi]),
            .REQ_SR  (req_sr[gi]),
            .WE      (we[gi]),
            .REG0    (reg0[gi]),
            .REG1    (reg1[gi]),
            .WD0     (wd0[gi]),
            .WD1     (wd1[gi]),
            .ACK     (ack[gi]),
            .RD0     (rd0[gi]),
            .RD1     (rd1[gi]),
            .VDC_CSn (csn[gi]),
            .VDC_WRn (wrn[gi]),
            .VDC_RDn (rdn[gi]),
            .VDC_A2  (a2[gi]),
            .VDC_DO  (vdo[gi]),
            .VDC_DI  (vdi[gi])
        );
        assign vdi[gi] = a2[gi] ? cmem[gi][rsel[gi]] : {10'b0, vd[gi], 5'b0};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic end_seg(input int i);
        log_q[i].push_back(cur[i]);
        if (cur[i].wr) begin
            if (!cur[i].a2) rsel[i] = cur[i].data[4:0];
            else cmem[i][rsel[i]] = cur[i].data;
        end else if (!cur[i].a2) begin
            vd[i] = 1'b0;
        end
        act[i] = 1'b0;
    endtask

    // One clock: observe the bus of every instance mid-cycle, then drive CE.
    task automatic tick();
        logic [18:0] k;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (csn[i] === 1'b0) begin
                k = {wrn[i], rdn[i], a2[i], vdo[i]};
                if (act[i] && k == key_r[i]) begin
                    cur[i].len = cur[i].len + 8'd1;
                end else begin
                    if (act[i]) end_seg(i);
                    act[i]      = 1'b1;
                    key_r[i]    = k;
                    cur[i].wr   = ~wrn[i];
                    cur[i].a2   = a2[i];
                    cur[i].data = wrn[i] ? 16'h0000 : vdo[i];
                    cur[i].len  = 8'd1;
                end
            end else if (act[i]) begin
                end_seg(i);
            end
        end
        cyc++;
        for (int i = 0; i < 3; i++) ce[i] = ce_en && (cyc % cepd[i] == 0);
    endtask

    // Expected bus segments, latency and read data for one access.
    task automatic plan(input int i, input int who, input bit sr, input bit w,
                        input logic [4:0] rg, input logic [15:0] wd,
                        output int lat, output logic [15:0] rdx);
        seg_t s;
        logic [7:0] ln;
        bit sel;
        ln  = 8'(stb_p[i] * cepd[i]);
        sel = !sr && !(skip_p[i] != 0 && shv[i] && shr[i] == rg);
        if (sel) begin
            s.wr = 1'b1; s.a2 = 1'b0; s.data = {11'b0, rg}; s.len = ln;
            exp_q[i].push_back(s);
            shv[i] = 1'b1;
            shr[i] = rg;
        end
        s.len = ln;
        if (sr) begin
            s.wr = 1'b0; s.a2 = 1'b0; s.data = 16'h0000;
            rdx = {10'b0, vd_exp[i], 5'b0};
            vd_exp[i] = 1'b0;
        end else if (w) begin
            s.wr = 1'b1; s.a2 = 1'b1; s.data = wd;
            emem[i][rg] = wd;
            rdx = erd[i][who];
        end else begin
            s.wr = 1'b0; s.a2 = 1'b1; s.data = 16'h0000;
            rdx = emem[i][rg];
        end
        exp_q[i].push_back(s);
        erd[i][who] = rdx;
        lat = sel ? 4 : 3;
    endtask

    task automatic drive(input int i, input int who, input bit sr, input bit w,
                         input logic [4:0] rg, input logic [15:0] wd);
        if (who == 0) begin
            reg0[i] = rg; wd0[i] = wd;
        end else begin
            reg1[i] = rg; wd1[i] = wd;
        end
        req_sr[i][who] = sr;
        we[i][who]     = w;
    endtask

    task automatic compare_log(input int i);
        seg_t a, e;
        chk("seg_count", log_q[i].size(), exp_q[i].size());
        while (log_q[i].size() > 0 && exp_q[i].size() > 0) begin
            a = log_q[i].pop_front();
            e = exp_q[i].pop_front();
            chk("bus_segment", a, e);
        end
        log_q[i].delete();
        exp_q[i].delete();
    endtask

    task automatic do_access(input int i, input int who, input bit sr, input bit w,
                             input logic [4:0] rg, input logic [15:0] wd);
        int lat, n;
        bit got;
        logic [15:0] rdx, oth;
        plan(i, who, sr, w, rg, wd, lat, rdx);
        oth = erd[i][1-who];
        drive(i, who, sr, w, rg, wd);
        req[i][who] = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            tick();
            n++;
            if (ack[i][who] === 1'b1) got = 1'b1;
        end
        chk("ack_seen", got, 1);
        chk("ack_onehot", ack[i], (who == 1) ? 2'b10 : 2'b01);
        req[i][who] = 1'b0;
        if (cepd[i] == 1) chk("latency", n, lat);
        chk("rd_own", (who == 1) ? rd1[i] : rd0[i], rdx);
        chk("rd_other", (who == 1) ? rd0[i] : rd1[i], oth);
        tick();
        chk("ack_pulse", ack[i], 2'b00);
        rrp[i] = (who == 0) ? 1 : 0;
        compare_log(i);
    endtask

    // Both requesters at once on instance 0; the first winner re-requests after its ACK.
    task automatic contend();
        int ord [3];
        logic [15:0] e_rd [3];
        int lat, n, k, w;
        ord[0] = rrp[0];
        ord[1] = 1 - rrp[0];
        ord[2] = rrp[0];
        for (int j = 0; j < 3; j++) begin
            if (j < 2 && ord[j] == 0) plan(0, 0, 1'b0, 1'b1, 5'h09, 16'h5A5A, lat, e_rd[j]);
            else if (j < 2) plan(0, 1, 1'b0, 1'b0, 5'h05, 16'h0000, lat, e_rd[j]);
            else plan(0, ord[2], 1'b0, 1'b1, 5'h0C, 16'hC3C3, lat, e_rd[j]);
        end
        drive(0, 0, 1'b0, 1'b1, 5'h09, 16'h5A5A);
        drive(0, 1, 1'b0, 1'b0, 5'h05, 16'h0000);
        req[0] = 2'b11;
        n = 0;
        k = 0;
        while (k < 3 && n < 300) begin
            tick();
            n++;
            if (ack[0] !== 2'b00) begin
                w = (ack[0] === 2'b10) ? 1 : 0;
                chk("contend_onehot", (ack[0] === 2'b01 || ack[0] === 2'b10), 1);
                chk("contend_order", w, ord[k]);
                chk("contend_rd", (w == 1) ? rd1[0] : rd0[0], e_rd[k]);
                req[0][w] = 1'b0;
                if (k == 0) begin
                    drive(0, w, 1'b0, 1'b1, 5'h0C, 16'hC3C3);
                    req[0][w] = 1'b1;
                end
                k++;
            end
        end
        chk("contend_done", k, 3);
        req[0] = 2'b00;
        tick();
        rrp[0] = 1 - ord[2];
        compare_log(0);
    endtask

    initial begin
        int who;
        bit sr, w;
        logic [4:0] rg;
        logic [15:0] v;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        ce_en    = 1'b0;
        cepd     = '{1, 1, 3};
        for (int i = 0; i < 3; i++) begin
            res[i] = 1'b1; ce[i] = 1'b0; req[i] = 2'b00; req_sr[i] = 2'b00; we[i] = 2'b00;
            reg0[i] = 5'h00; reg1[i] = 5'h00; wd0[i] = 16'h0000; wd1[i] = 16'h0000;
            rsel[i] = 5'h00; vd[i] = 1'b0; vd_exp[i] = 1'b0; act[i] = 1'b0;
            shv[i] = 1'b0; shr[i] = 5'h00; rrp[i] = 0; erd[i][0] = 16'h0000; erd[i][1] = 16'h0000;
            for (int r = 0; r < 32; r++) begin
                v = 16'($urandom);
                cmem[i][r] = v;
                emem[i][r] = v;
            end
        end

        // reset with CE held low
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            chk("reset_state", {csn[i], wrn[i], rdn[i], a2[i], ack[i], vdo[i]}, {4'b1110, 2'b00, 16'h0000});
        chk("reset_rd", {rd0[0], rd1[0]}, 32'h0);
        for (int i = 0; i < 3; i++) res[i] = 1'b0;
        ce_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            log_q[i].delete();
            exp_q[i].delete();
        end

        do_access(0, 0, 1'b0, 1'b1, 5'h05, 16'h00C8);
        do_access(0, 0, 1'b0, 1'b1, 5'h05, 16'h1234);
        do_access(0, 0, 1'b0, 1'b1, 5'h00, 16'h0020);
        do_access(0, 1, 1'b0, 1'b0, 5'h00, 16'h0000);
        vd[0] = 1'b1;
        vd_exp[0] = 1'b1;
        do_access(0, 0, 1'b1, 1'b0, 5'h1F, 16'h0000);
        chk("vd_cleared", vd[0], 1'b0);
        do_access(0, 1, 1'b0, 1'b0, 5'h00, 16'h0000);

        // reset during SEL
        drive(0, 0, 1'b0, 1'b1, 5'h09, 16'hBEEF);
        req[0] = 2'b01;
        tick();
        chk("midsel_strobe", {csn[0], a2[0]}, 2'b00);
        res[0] = 1'b1;
        tick();
        chk("midsel_release", {csn[0], wrn[0], rdn[0], ack[0]}, 5'b11100);
        req[0] = 2'b00;
        res[0] = 1'b0;
        tick();
        chk("midsel_noack", ack[0], 2'b00);
        chk("midsel_rd", {rd0[0], rd1[0]}, 32'h0);
        shv[0] = 1'b0; rrp[0] = 0; erd[0][0] = 16'h0000; erd[0][1] = 16'h0000;
        log_q[0].delete();
        exp_q[0].delete();

        contend();

        for (int t = 0; t < 24; t++) begin
            who = $urandom_range(0, 1);
            sr  = ($urandom_range(0, 7) == 0);
            w   = $urandom_range(0, 1);
            rg  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            do_access(0, who, sr, w, rg, 16'($urandom));
        end

        do_access(1, 0, 1'b0, 1'b1, 5'h03, 16'hA0A0);
        do_access(1, 0, 1'b0, 1'b1, 5'h03, 16'h0B0B);
        do_access(1, 1, 1'b0, 1'b0, 5'h03, 16'h0000);

        do_access(2, 0, 1'b0, 1'b1, 5'h14, 16'h7E57);
        do_access(2, 1, 1'b0, 1'b0, 5'h14, 16'h0000);
        vd[2] = 1'b1;
        vd_exp[2] = 1'b1;
        do_access(2, 1, 1'b1, 1'b0, 5'h00, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
